alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Issue controller that shares the single combinational ALU between two requesters. Candidates are the pipeline execute path (req0) and the multi-cycle helper unit (req1).
- Arbitrates round-robin with valid/ready handshakes.
- Drives the ALU operand and opcode inputs, and registers the ALU result into a one-deep response slot.
- Keeps a per-requester Z/V/N flag register, updated with the per-opcode flag-write rules.

Parameters:
DW, 16, data width of operands and result
OPW, 3, opcode width
RR_INIT, 0, requester that wins the first tie after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_op  in  OPW  requester 0 opcode
req0_a  in  DW  requester 0 operand 1
req0_b  in  DW  requester 0 operand 2
req1_valid/req1_ready/req1_op/req1_a/req1_b  same as req0, for requester 1
alu_in1  out  DW  to ALU operand 1
alu_in2  out  DW  to ALU operand 2
alu_opcode  out  OPW  to ALU opcode
alu_out  in  DW  ALU result
alu_err  in  1  ALU overflow/error
rsp_valid  out  1  response slot full
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester that owns the response
rsp_data  out  DW  registered result
rsp_error  out  1  registered ALU error
flags0  out  3  requester 0 flags {Z,V,N}
flags1  out  3  requester 1 flags {Z,V,N}

Behaviour:
- One clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_error=0, flags0=flags1=0.
  - RR pointer set so RR_INIT wins the next tie.
  - Reset asserted mid-operation discards any held response; a request in the same cycle is not granted.
- can_issue = !rsp_valid || rsp_ready. A slot draining this cycle may be refilled in the same cycle.
- Grant (combinational):
  - Only when can_issue and at least one valid.
  - A single valid requester wins.
  - If both are valid, the requester not granted last wins.
  - The RR pointer updates only on a grant.
- reqN_ready = can_issue && grant==N. A transfer occurs when valid && ready.
- ALU inputs:
  - alu_in1/alu_in2/alu_opcode mux the granted requester's fields in the same cycle.
  - With no grant they drive 0/0/000.
  - The ALU is combinational, so the result is captured at the same edge.
- Latency: a request accepted in cycle N gives rsp_valid=1 in cycle N+1.
- rsp_data/rsp_id/rsp_error stay stable while rsp_valid && !rsp_ready. No new grant while stalled.
- rsp_valid clears when consumed with no new grant.
- Flags are computed from alu_out at capture and written only into the granted requester's register; the other requester's register is unchanged.
  - Z = (alu_out==0), V = alu_err, N = alu_out[DW-1].
  - Write mask:
    - op 000 ADD and 001 SUB write Z,V,N.
    - op 010 XOR, 100 SLL, 101 SRA, 110 ROR write Z only; V,N hold.
    - op 011 RED and 111 PADDSB write nothing.
- Flag update and response capture happen on the same edge.

Optional Feature:
ALU_STICKY_ERR_EN
- With it:
  - Adds ports err_sticky out 2 and err_clr in 2.
  - err_sticky[N] sets when a captured response for requester N has rsp_error=1 and holds until err_clr[N].
  - Set wins over a simultaneous clear.
  - Reset value 0.
- Without it: the ports and state are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_issue_pkg:
  - opcode localparams (OP_ADD..OP_PADDSB).
  - flag index constants FLG_Z=2, FLG_V=1, FLG_N=0.
  - function returning the 3-bit write mask for an opcode.
- One natural sub-module: rr_arb2 (2-way round-robin arbiter with pointer register, inputs req[1:0] and en, output gnt[1:0]).

Test Plan:
- req0 ADD a=0x7FFF b=0x0001 (ALU model returns 0x8000, err=1) -> next cycle rsp_valid=1, rsp_id=0, rsp_data=0x8000, rsp_error=1, flags0=3'b011, flags1=000.
- Then req0 XOR a=b=0x1234 -> rsp_data=0, flags0=3'b111 (Z set, V/N held); then RED -> flags0 unchanged.
- Both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1 starting RR_INIT; one response per cycle.
- rsp_ready=0 for 3 cycles with both valid -> req0_ready=req1_ready=0, rsp fields stable; first cycle rsp_ready=1 -> next grant issued same cycle.
- rst pulsed while rsp_valid=1 and requests pending -> next cycle all outputs at reset values; the first tie goes to RR_INIT.
- ALU_STICKY_ERR_EN: req1 SUB overflow -> err_sticky=2'b10; err_clr=2'b10 alone clears it; a simultaneous error and clear keeps it set.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller: opcode encodings,
// flag bit positions and the per-opcode flag write mask.
package alu_issue_pkg;

  // ALU opcode encodings
  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  // Bit positions inside a {Z,V,N} flag vector
  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  // Which flag bits an opcode is allowed to write; bits left at 0 hold.
  function automatic logic [2:0] flag_wmask(input logic [2:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m[FLG_Z] = 1'b1;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last winner so
// that on a tie the other requester is served. Grants only when en is high.
module alu_issue_ctrl_rr_arb2 #(
  parameter int RR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // Reset the "last winner" to the opposite of RR_INIT so RR_INIT wins first.
  localparam logic L_LAST_INIT = (RR_INIT == 0) ? 1'b1 : 1'b0;

  logic r_last;

  // Grant decision: single requester wins, tie goes to the one not served last.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = r_last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer moves only when a grant is actually given.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= L_LAST_INIT;
    end else if (|gnt) begin
      r_last <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller sharing one combinational ALU between two requesters.
// Round-robin grant, one-deep registered response slot, per-requester
// {Z,V,N} flag registers.
// Optional: define ALU_STICKY_ERR_EN to add sticky per-requester error bits
// (ports err_sticky / err_clr).
//
// Handshake: every channel is valid/ready; a transfer happens on a clock edge
// where both are high. Requesters may hold valid indefinitely; ready is only
// raised for the granted requester while the response slot can accept.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int DW      = 16,
  parameter int OPW     = 3,
  parameter int RR_INIT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic [DW-1:0]  alu_in1,
  output logic [DW-1:0]  alu_in2,
  output logic [OPW-1:0] alu_opcode,
  input  logic [DW-1:0]  alu_out,
  input  logic           alu_err,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_error,
  output logic [2:0]     flags0,
  output logic [2:0]     flags1
`ifdef ALU_STICKY_ERR_EN
  ,
  output logic [1:0]     err_sticky,
  input  logic [1:0]     err_clr
`endif
);

  logic          r_rsp_valid;
  logic          r_rsp_id;
  logic [DW-1:0] r_rsp_data;
  logic          r_rsp_error;
  logic [2:0]    r_flags0;
  logic [2:0]    r_flags1;

  logic          w_can_issue;
  logic          w_arb_en;
  logic [1:0]    w_gnt;
  logic          w_issue;
  logic          w_gnt_id;
  logic [2:0]    w_mask;
  logic [2:0]    w_new_flags;

  // Slot accepts a new result when empty or being drained this cycle.
  // Requests seen during reset are never granted.
  assign w_can_issue = !r_rsp_valid || rsp_ready;
  assign w_arb_en    = w_can_issue && !rst;

  alu_issue_ctrl_rr_arb2 #(
    .RR_INIT (RR_INIT)
  ) u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1_valid, req0_valid}),
    .en  (w_arb_en),
    .gnt (w_gnt)
  );

  assign w_issue    = |w_gnt;
  assign w_gnt_id   = w_gnt[1];
  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  // ALU operand mux: granted requester's fields, zeros when idle.
  always_comb begin
    alu_in1    = '0;
    alu_in2    = '0;
    alu_opcode = '0;
    if (w_gnt[0]) begin
      alu_in1    = req0_a;
      alu_in2    = req0_b;
      alu_opcode = req0_op;
    end else if (w_gnt[1]) begin
      alu_in1    = req1_a;
      alu_in2    = req1_b;
      alu_opcode = req1_op;
    end
  end

  // Flags derived from the live ALU result and masked by opcode.
  assign w_mask             = flag_wmask(alu_opcode);
  assign w_new_flags[FLG_Z] = (alu_out == '0);
  assign w_new_flags[FLG_V] = alu_err;
  assign w_new_flags[FLG_N] = alu_out[DW-1];

  // Response slot: capture on grant, clear when drained with nothing new.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
    end else if (w_issue) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_gnt_id;
      r_rsp_data  <= alu_out;
      r_rsp_error <= alu_err;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Flag registers: only the granted requester's copy is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags0 <= 3'b000;
      r_flags1 <= 3'b000;
    end else if (w_issue) begin
      if (!w_gnt_id) begin
        r_flags0 <= (r_flags0 & ~w_mask) | (w_new_flags & w_mask);
      end else begin
        r_flags1 <= (r_flags1 & ~w_mask) | (w_new_flags & w_mask);
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign rsp_error = r_rsp_error;
  assign flags0    = r_flags0;
  assign flags1    = r_flags1;

`ifdef ALU_STICKY_ERR_EN
  logic [1:0] r_err_sticky;
  logic [1:0] w_err_set;

  assign w_err_set = {w_issue &&  w_gnt_id && alu_err,
                      w_issue && !w_gnt_id && alu_err};

  // Sticky error bits: a new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_sticky <= 2'b00;
    end else begin
      r_err_sticky <= (r_err_sticky & ~err_clr) | w_err_set;
    end
  end

  assign err_sticky = r_err_sticky;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed vectors, expected responses queued by
// the stimulus and checked by an independent monitor. Includes a behavioural
// ALU model. Build with ALU_STICKY_ERR_EN to exercise the sticky error bits.
module tb_alu_issue_ctrl;

  localparam int DW  = 16;
  localparam int OPW = 3;

  logic           clk;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic           req0_ready, req1_ready;
  logic [OPW-1:0] req0_op, req1_op;
  logic [DW-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [DW-1:0]  alu_in1, alu_in2, alu_out;
  logic [OPW-1:0] alu_opcode;
  logic           alu_err;
  logic           rsp_valid, rsp_ready, rsp_id, rsp_error;
  logic [DW-1:0]  rsp_data;
  logic [2:0]     flags0, flags1;
`ifdef ALU_STICKY_ERR_EN
  logic [1:0]     err_sticky, err_clr;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // expected response: {id, data, err, flags0, flags1}
  logic [23:0] exp_q[$];

  alu_issue_ctrl #(.DW(DW), .OPW(OPW), .RR_INIT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_err    (alu_err),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_error  (rsp_error),
    .flags0     (flags0),
    .flags1     (flags1)
`ifdef ALU_STICKY_ERR_EN
    ,
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  function automatic logic [7:0] sadd8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] s;
    s = x + y;
    if (x[7] == y[7] && s[7] != x[7]) s = x[7] ? 8'h80 : 8'h7F;
    return s;
  endfunction

  always_comb begin
    logic [31:0] dbl;
    alu_out = '0;
    alu_err = 1'b0;
    dbl     = '0;
    case (alu_opcode)
      3'b000: begin
        alu_out = alu_in1 + alu_in2;
        alu_err = (alu_in1[15] == alu_in2[15]) && (alu_out[15] != alu_in1[15]);
      end
      3'b001: begin
        alu_out = alu_in1 - alu_in2;
        alu_err = (alu_in1[15] != alu_in2[15]) && (alu_out[15] != alu_in1[15]);
      end
      3'b010: alu_out = alu_in1 ^ alu_in2;
      3'b011: alu_out = {15'd0, ^alu_in1};
      3'b100: alu_out = alu_in1 << alu_in2[3:0];
      3'b101: alu_out = 16'($signed(alu_in1) >>> alu_in2[3:0]);
      3'b110: begin
        dbl     = {alu_in1, alu_in1} >> alu_in2[3:0];
        alu_out = dbl[15:0];
      end
      default: alu_out = {sadd8(alu_in1[15:8], alu_in2[15:8]), sadd8(alu_in1[7:0], alu_in2[7:0])};
    endcase
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [23:0] mk(input logic id, input logic [15:0] d, input logic e,
                                     input logic [2:0] f0, input logic [2:0] f1);
    return {id, d, e, f0, f1};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [23:0] e;
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_data), 32'hFFFF_FFFF);
      end else begin
        e = rsp_ready ? exp_q.pop_front() : exp_q[0];
        chk(rsp_ready ? "rsp_id" : "stall_id", 32'(rsp_id), 32'(e[23]));
        chk(rsp_ready ? "rsp_data" : "stall_data", 32'(rsp_data), 32'(e[22:7]));
        chk(rsp_ready ? "rsp_error" : "stall_error", 32'(rsp_error), 32'(e[6]));
        chk("flags0", 32'(flags0), 32'(e[5:3]));
        chk("flags1", 32'(flags1), 32'(e[2:0]));
      end
    end
  end

  // ---------------- driver ----------------
  // One cycle: drive requests, check grant at negedge, queue expected result.
  task automatic cyc(input logic v0, input logic [2:0] op0, input logic [15:0] a0, input logic [15:0] b0,
                     input logic v1, input logic [2:0] op1, input logic [15:0] a1, input logic [15:0] b1,
                     input int g, input logic [23:0] e);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    @(negedge clk);
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    if (g >= 0) exp_q.push_back(e);
    else begin
      chk("idle_alu_in", 32'({alu_in1, alu_in2}), 32'd0);
      chk("idle_alu_op", 32'(alu_opcode), 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_error", 32'(rsp_error), 32'd0);
    chk("rst_flags0", 32'(flags0), 32'd0);
    chk("rst_flags1", 32'(flags1), 32'd0);
`ifdef ALU_STICKY_ERR_EN
    chk("rst_sticky", 32'(err_sticky), 32'd0);
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
`ifdef ALU_STICKY_ERR_EN
    err_clr = 2'b00;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;

    // ADD overflow, XOR to zero (Z only), RED (no flags)
    cyc(1, 3'b000, 16'h7FFF, 16'h0001, 0, 3'b000, 16'h0, 16'h0, 0, mk(0, 16'h8000, 1, 3'b011, 3'b000));
    cyc(1, 3'b010, 16'h1234, 16'h1234, 0, 3'b000, 16'h0, 16'h0, 0, mk(0, 16'h0000, 0, 3'b111, 3'b000));
    cyc(1, 3'b011, 16'h0001, 16'h0000, 0, 3'b000, 16'h0, 16'h0, 0, mk(0, 16'h0001, 0, 3'b111, 3'b000));
    cyc(0, 3'b000, 16'h0, 16'h0, 0, 3'b000, 16'h0, 16'h0, -1, 24'd0);

    // SUB without overflow, then hold the slot for three cycles
    cyc(1, 3'b001, 16'h0005, 16'h0003, 0, 3'b000, 16'h0, 16'h0, 0, mk(0, 16'h0002, 0, 3'b000, 3'b000));
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc(1, 3'b001, 16'h0005, 16'h0003, 1, 3'b000, 16'h4000, 16'h4000, -1, 24'd0);
    // drain and refill in the same cycle; last winner was 0 so 1 wins the tie
    rsp_ready = 1'b1;
    cyc(1, 3'b001, 16'h0005, 16'h0003, 1, 3'b000, 16'h4000, 16'h4000, 1, mk(1, 16'h8000, 1, 3'b000, 3'b011));

    // reset while a response is held and both requests pending
    rsp_ready = 1'b0;
    rst = 1'b1;
    cyc(1, 3'b001, 16'h0005, 16'h0003, 1, 3'b000, 16'h4000, 16'h4000, -1, 24'd0);
    exp_q.delete();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk_reset_vals();
    @(posedge clk); #1;

    // continuous tie: alternate 0,1,0,1 starting with RR_INIT
    cyc(1, 3'b010, 16'h00FF, 16'h0F0F, 1, 3'b001, 16'h0000, 16'h0000, 0, mk(0, 16'h0FF0, 0, 3'b000, 3'b000));
    cyc(1, 3'b010, 16'h00FF, 16'h0F0F, 1, 3'b001, 16'h0000, 16'h0000, 1, mk(1, 16'h0000, 0, 3'b000, 3'b100));
    cyc(1, 3'b010, 16'h00FF, 16'h0F0F, 1, 3'b001, 16'h0000, 16'h0000, 0, mk(0, 16'h0FF0, 0, 3'b000, 3'b100));
    cyc(1, 3'b010, 16'h00FF, 16'h0F0F, 1, 3'b001, 16'h0000, 16'h0000, 1, mk(1, 16'h0000, 0, 3'b000, 3'b100));

    // PADDSB writes no flags; ROR writes Z only
    cyc(0, 3'b000, 16'h0, 16'h0, 1, 3'b111, 16'h7F01, 16'h0101, 1, mk(1, 16'h7F02, 0, 3'b000, 3'b100));
    cyc(0, 3'b000, 16'h0, 16'h0, 1, 3'b110, 16'h0001, 16'h0001, 1, mk(1, 16'h8000, 0, 3'b000, 3'b000));

`ifdef ALU_STICKY_ERR_EN
    cyc(0, 3'b000, 16'h0, 16'h0, 1, 3'b001, 16'h8000, 16'h0001, 1, mk(1, 16'h7FFF, 1, 3'b000, 3'b010));
    chk("sticky_set", 32'(err_sticky), 32'h2);
    err_clr = 2'b10;
    cyc(0, 3'b000, 16'h0, 16'h0, 0, 3'b000, 16'h0, 16'h0, -1, 24'd0);
    chk("sticky_clr", 32'(err_sticky), 32'h0);
    cyc(0, 3'b000, 16'h0, 16'h0, 1, 3'b001, 16'h8000, 16'h0001, 1, mk(1, 16'h7FFF, 1, 3'b000, 3'b010));
    chk("sticky_set_wins", 32'(err_sticky), 32'h2);
    err_clr = 2'b00;
`endif

    // drain
    cyc(0, 3'b000, 16'h0, 16'h0, 0, 3'b000, 16'h0, 16'h0, -1, 24'd0);
    cyc(0, 3'b000, 16'h0, 16'h0, 0, 3'b000, 16'h0, 16'h0, -1, 24'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
